// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: captures request edges into pending bits and offers the highest enabled one over valid/ack
module irq_pending_arbiter #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       vec_ack,
  output logic       vec_valid,
  output logic [2:0] vec,
  output logic [7:0] pending,
  output logic [7:0] overrun
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_req_q, r_pending, r_overrun;
  logic [7:0] w_rise, w_clr, w_elig, w_pending_nxt, w_overrun_nxt;
  logic [2:0] r_vec, w_vec_nxt, w_sel;
  logic       w_ack;
  assign w_ack         = (r_state == OFFER) && vec_ack;
  assign w_rise        = req & ~r_req_q;
  assign w_clr         = w_ack ? (8'd1 << r_vec) : 8'd0;
  assign w_elig        = r_pending & mask;
  assign w_pending_nxt = (EDGE_MODE != 0) ? ((r_pending & ~w_clr) | w_rise) : req;
  assign w_overrun_nxt = (r_overrun | (w_rise & r_pending)) & ~w_clr;
  assign vec_valid     = (r_state == OFFER);
  assign vec           = r_vec;
  assign pending       = r_pending;
  assign overrun       = r_overrun;
  // highest set bit of the eligible lines wins
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) w_sel = w_elig[i] ? 3'(i) : w_sel;
  end
  // offer is latched on entry to OFFER and held until acknowledged
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    if (r_state == IDLE) begin
      w_state_nxt = (w_elig != 8'd0) ? OFFER : IDLE;
      w_vec_nxt   = (w_elig != 8'd0) ? w_sel : r_vec;
    end else begin
      w_state_nxt = vec_ack ? IDLE : OFFER;
    end
  end
  // state, offer and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_vec     <= 3'd0;
      r_req_q   <= 8'd0;
      r_pending <= 8'd0;
      r_overrun <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_vec     <= w_vec_nxt;
      r_req_q   <= req;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end
endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Sequential front end for the 8-to-3 priority encoding path.
- Captures eight raw request lines into a pending register and applies a per-line enable mask.
- Selects the highest-index pending, enabled line (bit 7 highest, code 3'b111; bit 0 lowest, code 3'b000).
- Offers the selected index to a downstream consumer over a valid/ack handshake.
- Clears the serviced pending bit when the consumer acknowledges.

## Interface
Parameters:
- EDGE_MODE, default 1: 1 = capture rising edges of req into sticky pending bits; 0 = level mode, pending mirrors registered req.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  raw request lines, synchronous to clk.
- mask  input  8  per-line enable; 1 = eligible for selection.
- vec_ack  input  1  consumer accepts the current offer.
- vec_valid  output  1  an offer is presented on vec.
- vec  output  3  index of the offered line.
- pending  output  8  current pending register.
- overrun  output  8  sticky per-line flag: a new edge arrived while that line was already pending.

## Operation
- Reset (rst_n low, asynchronous) clears req_q, pending, overrun, vec and vec_valid to 0, and puts the FSM in IDLE.
- Edge detect: rise = req & ~req_q, with req_q registered every cycle. A line high at reset release counts as a rise.
- Pending update, EDGE_MODE=1: pending <= (pending & ~clr) | rise.
  - clr is a one-hot of vec, active only in the cycle vec_valid & vec_ack.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Pending update, EDGE_MODE=0: pending <= req. vec_ack does not clear pending; the source must drop req.
- Mask does not gate capture. Masked lines accumulate pending and overrun but are never offered.
- overrun[i] is set when rise[i] & pending[i] and clr[i] is not active. It is cleared when line i is acknowledged.
- elig = pending & mask. The selected index is the highest set bit of elig.
- FSM states:
  - IDLE: vec_valid=0. If elig != 0, latch vec = select(elig), set vec_valid=1 and go to OFFER. Otherwise stay in IDLE.
  - OFFER: vec_valid=1 and vec held stable, even if mask or pending change; there is no retraction. On vec_ack: vec_valid=0, clear pending[vec] and overrun[vec], go to IDLE. Without vec_ack, stay in OFFER.
- A higher-priority line arriving during OFFER does not pre-empt the offer. It is selected at the next IDLE evaluation.
- vec_ack while in IDLE is ignored.

## Timing
- req first sampled high at edge k: pending bit set at edge k, vec_valid high after edge k+1. Minimum latency is 2 edges.
- vec_ack sampled high at edge m: vec_valid low after edge m. The next offer, if elig != 0, is valid after edge m+1.
- There is therefore exactly one idle cycle between consecutive offers. Back-to-back service rate is one line per 2 cycles plus consumer wait.
- vec and vec_valid are registered outputs with no combinational path from inputs.
- pending and overrun are registered.
- Reset asserted mid-offer drops vec_valid immediately (asynchronously). All pending events are lost.

## Test plan
- Reset, then pulse req=8'b00000100 for 1 cycle with mask=8'hFF -> vec_valid rises 2 edges later with vec=3'b010; ack -> pending=8'h00, vec_valid low.
- req=8'b10100001 (one edge), mask=8'hFF, ack each offer immediately -> vec sequence 3'b111, 3'b101, 3'b000, each separated by one idle cycle, then pending=0.
- mask=8'b01111111 with req bit7 and bit3 risen -> offer vec=3'b011 only; bit7 stays pending; later set mask bit7 -> next offer vec=3'b111.
- Offer vec=3'b001 held without ack; re-pulse req[1] -> overrun[1]=1, vec unchanged; then ack -> overrun[1]=0, pending[1]=0.
- Rise on req[4] in the same cycle as ack of vec=3'b100 -> pending[4] stays 1, next offer vec=3'b100, overrun[4]=0.
- EDGE_MODE=0, hold req=8'b00010000 then ack -> re-offered vec=3'b100 until req drops; assert rst_n low during OFFER -> vec_valid=0 and pending=0 immediately.
